// File: rtl/dbus_if.sv
// Data-bus bridge: turns the memory stage's single-cycle RAM request into a
// Wishbone cyc/stb/ack transaction and holds the pipeline until it resolves.
module dbus_if #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        cpu_ce_i,
    input  logic        cpu_we_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq_o,
    output logic        bus_err_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    typedef enum logic [1:0] {IDLE, BUSY, WAIT_STALL} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       rd_buf;
    logic              timeout_hit;

    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = '0;
        case (state)
            IDLE:       stallreq_o = cpu_ce_i & ~flush_i;
            BUSY: begin
                if (wb_ack_i) cpu_data_o = wb_dat_i;
                else          stallreq_o = ~flush_i & ~timeout_hit;
            end
            WAIT_STALL: cpu_data_o = rd_buf;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rd_buf    <= '0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            wb_we_o   <= 1'b0;
            wb_sel_o  <= '0;
            wb_stb_o  <= 1'b0;
            wb_cyc_o  <= 1'b0;
            bus_err_o <= 1'b0;
        end else begin
            bus_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_ce_i && !flush_i) begin
                        wb_adr_o <= cpu_addr_i;
                        wb_dat_o <= cpu_data_i;
                        wb_we_o  <= cpu_we_i;
                        wb_sel_o <= cpu_sel_i;
                        wb_stb_o <= 1'b1;
                        wb_cyc_o <= 1'b1;
                        cnt      <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    // ack wins over flush and timeout; a flushed ack still ends the cycle
                    if (wb_ack_i) begin
                        wb_stb_o <= 1'b0;
                        wb_cyc_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        wb_sel_o <= '0;
                        rd_buf   <= wb_dat_i;
                        state    <= (stall_i && !flush_i) ? WAIT_STALL : IDLE;
                    end else if (flush_i) begin
                        wb_stb_o <= 1'b0;
                        wb_cyc_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        wb_sel_o <= '0;
                        state    <= IDLE;
                    end else if (timeout_hit) begin
                        wb_stb_o  <= 1'b0;
                        wb_cyc_o  <= 1'b0;
                        wb_we_o   <= 1'b0;
                        wb_sel_o  <= '0;
                        rd_buf    <= '0;
                        bus_err_o <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_STALL: begin
                    if (!stall_i || flush_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dbus_if.sv
// Bench for dbus_if: transaction-level model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_dbus_if;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst, stall_i, flush_i, cpu_ce_i, cpu_we_i, wb_ack_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_addr_i, cpu_data_i, wb_dat_i;
    logic [31:0] cpu_data_o, wb_adr_o, wb_dat_o;
    logic        stallreq_o, bus_err_o, wb_we_o, wb_stb_o, wb_cyc_o;
    logic [3:0]  wb_sel_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dbus_if #(.TIMEOUT(TO), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_sel_i(cpu_sel_i),
        .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
        .cpu_data_o(cpu_data_o), .stallreq_o(stallreq_o), .bus_err_o(bus_err_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding request, its age, and held read data
    bit          m_act, m_hold, m_hold_we, m_err, m_zero, m_ackend, m_we;
    logic [31:0] m_adr, m_dat, m_hold_data;
    logic [3:0]  m_sel;
    int          m_age;

    initial begin
        bit tmo, e_stall;
        m_act = 0; m_hold = 0; m_err = 0; m_zero = 1; m_ackend = 0; m_age = 0;
        forever begin
            @(negedge clk);
            tmo = m_act && !wb_ack_i && !flush_i && (m_age == TO - 1);
            if (m_act)       e_stall = !wb_ack_i && !flush_i && !tmo;
            else if (m_hold) e_stall = 0;
            else             e_stall = cpu_ce_i && !flush_i;
            check("m_cyc", {31'd0, wb_cyc_o}, {31'd0, m_act});
            check("m_stb", {31'd0, wb_stb_o}, {31'd0, m_act});
            check("m_err", {31'd0, bus_err_o}, {31'd0, m_err});
            check("m_stallreq", {31'd0, stallreq_o}, {31'd0, e_stall});
            if (m_act) begin
                check("m_adr", wb_adr_o, m_adr);
                check("m_dat", wb_dat_o, m_dat);
                check("m_we", {31'd0, wb_we_o}, {31'd0, m_we});
                check("m_sel", {28'd0, wb_sel_o}, {28'd0, m_sel});
            end else if (m_zero) begin
                check("m_adr0", wb_adr_o, 32'd0);
                check("m_dat0", wb_dat_o, 32'd0);
                check("m_we0", {31'd0, wb_we_o}, 32'd0);
                check("m_sel0", {28'd0, wb_sel_o}, 32'd0);
            end else if (m_ackend) begin
                check("m_we_after_ack", {31'd0, wb_we_o}, 32'd0);
                check("m_sel_after_ack", {28'd0, wb_sel_o}, 32'd0);
            end
            if (m_act && wb_ack_i && !flush_i && !m_we) check("m_rdata", cpu_data_o, wb_dat_i);
            else if (m_hold && !m_hold_we)             check("m_hold_data", cpu_data_o, m_hold_data);
            else if (!m_act && !m_hold)                check("m_idle_data", cpu_data_o, 32'd0);

            @(posedge clk);
            if (rst) begin
                m_act = 0; m_hold = 0; m_err = 0; m_zero = 1; m_ackend = 0;
            end else begin
                m_err = 0;
                if (m_act) begin
                    if (wb_ack_i) begin
                        m_act = 0; m_ackend = 1;
                        if (stall_i && !flush_i) begin
                            m_hold = 1; m_hold_we = m_we; m_hold_data = wb_dat_i;
                        end
                    end else if (flush_i) begin
                        m_act = 0; m_ackend = 0;
                    end else if (tmo) begin
                        m_act = 0; m_ackend = 0; m_err = 1;
                    end else begin
                        m_age++;
                    end
                end else if (m_hold) begin
                    if (!stall_i || flush_i) m_hold = 0;
                end else if (cpu_ce_i && !flush_i) begin
                    m_act = 1; m_zero = 0; m_age = 0;
                    m_adr = cpu_addr_i; m_dat = cpu_data_i; m_we = cpu_we_i; m_sel = cpu_sel_i;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                       input logic [31:0] dat);
        cpu_ce_i = 1'b1; cpu_we_i = we; cpu_sel_i = sel; cpu_addr_i = adr; cpu_data_i = dat;
    endtask

    initial begin
        rst = 1; stall_i = 0; flush_i = 0; cpu_ce_i = 0; cpu_we_i = 0; wb_ack_i = 0;
        cpu_sel_i = '0; cpu_addr_i = '0; cpu_data_i = '0; wb_dat_i = '0;
        step(); step();
        rst = 0;
        @(negedge clk);
        check("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        check("rst_adr", wb_adr_o, 32'd0);
        check("rst_err", {31'd0, bus_err_o}, 32'd0);
        check("rst_data", cpu_data_o, 32'd0);

        // 1: read with two wait states
        step(); req(0, 4'hF, 32'h100, 32'h0);
        @(negedge clk); check("t1_req_stall", {31'd0, stallreq_o}, 32'd1);
        step(); @(negedge clk); check("t1_stb_b1", {31'd0, wb_stb_o}, 32'd1);
        check("t1_adr", wb_adr_o, 32'h100);
        step(); @(negedge clk); check("t1_stb_b2", {31'd0, wb_stb_o}, 32'd1);
        step(); wb_ack_i = 1; wb_dat_i = 32'hDEADBEEF;
        @(negedge clk); check("t1_stb_b3", {31'd0, wb_stb_o}, 32'd1);
        check("t1_data", cpu_data_o, 32'hDEADBEEF);
        check("t1_stall_ack", {31'd0, stallreq_o}, 32'd0);
        step(); wb_ack_i = 0; wb_dat_i = 0; cpu_ce_i = 0;
        @(negedge clk); check("t1_stb_end", {31'd0, wb_stb_o}, 32'd0);

        // 2: byte store, zero-wait ack
        step(); req(1, 4'b0100, 32'h204, 32'h5A5A5A5A);
        @(negedge clk); check("t2_req_stall", {31'd0, stallreq_o}, 32'd1);
        step(); wb_ack_i = 1;
        @(negedge clk); check("t2_we", {31'd0, wb_we_o}, 32'd1);
        check("t2_sel", {28'd0, wb_sel_o}, 32'h4);
        check("t2_dat", wb_dat_o, 32'h5A5A5A5A);
        check("t2_stall_ack", {31'd0, stallreq_o}, 32'd0);
        step(); wb_ack_i = 0; cpu_ce_i = 0;
        @(negedge clk); check("t2_we_end", {31'd0, wb_we_o}, 32'd0);
        check("t2_sel_end", {28'd0, wb_sel_o}, 32'd0);

        // 3: ack while another unit stalls the pipeline
        step(); req(0, 4'hF, 32'h300, 32'h0);
        step(); wb_ack_i = 1; wb_dat_i = 32'h12345678; stall_i = 1;
        @(negedge clk); check("t3_data_ack", cpu_data_o, 32'h12345678);
        step(); wb_ack_i = 0; wb_dat_i = 32'hFFFF0000;
        @(negedge clk); check("t3_data_w1", cpu_data_o, 32'h12345678);
        check("t3_stall_w1", {31'd0, stallreq_o}, 32'd0);
        step(); stall_i = 0;
        @(negedge clk); check("t3_data_w2", cpu_data_o, 32'h12345678);
        check("t3_no_new_stb", {31'd0, wb_stb_o}, 32'd0);
        step(); cpu_ce_i = 0;
        @(negedge clk); check("t3_idle_data", cpu_data_o, 32'd0);

        // 4: no ack, timeout after TO busy cycles
        step(); req(0, 4'hF, 32'h400, 32'h0);
        for (int i = 1; i <= TO; i++) begin
            step();
            @(negedge clk);
            check("t4_stb_busy", {31'd0, wb_stb_o}, 32'd1);
            check("t4_stall_busy", {31'd0, stallreq_o}, (i < TO) ? 32'd1 : 32'd0);
        end
        step(); cpu_ce_i = 0;
        @(negedge clk); check("t4_stb_drop", {31'd0, wb_stb_o}, 32'd0);
        check("t4_err", {31'd0, bus_err_o}, 32'd1);
        check("t4_data", cpu_data_o, 32'd0);
        step();
        @(negedge clk); check("t4_err_pulse", {31'd0, bus_err_o}, 32'd0);

        // 5a: flush in second busy cycle, stray ack afterwards
        step(); req(0, 4'hF, 32'h500, 32'h0);
        step();
        step(); flush_i = 1;
        @(negedge clk); check("t5_stall_flush", {31'd0, stallreq_o}, 32'd0);
        step(); flush_i = 0; cpu_ce_i = 0;
        @(negedge clk); check("t5_cyc_drop", {31'd0, wb_cyc_o}, 32'd0);
        check("t5_no_err", {31'd0, bus_err_o}, 32'd0);
        step(); wb_ack_i = 1; wb_dat_i = 32'hCAFEF00D;
        @(negedge clk); check("t5_late_ack_data", cpu_data_o, 32'd0);
        step(); wb_ack_i = 0; wb_dat_i = 0;
        @(negedge clk); check("t5_late_ack_stb", {31'd0, wb_stb_o}, 32'd0);

        // 5b: ack and flush together while stalled -> IDLE, not WAIT_STALL
        step(); req(0, 4'hF, 32'h600, 32'h0);
        step(); wb_ack_i = 1; flush_i = 1; stall_i = 1; wb_dat_i = 32'hAAAA5555;
        @(negedge clk); check("t5b_stall", {31'd0, stallreq_o}, 32'd0);
        step(); wb_ack_i = 0; flush_i = 0; req(0, 4'hF, 32'h700, 32'h0);
        @(negedge clk); check("t5b_err", {31'd0, bus_err_o}, 32'd0);
        check("t5b_idle_accept", {31'd0, stallreq_o}, 32'd1);
        step(); stall_i = 0; wb_ack_i = 1; wb_dat_i = 32'h0BADC0DE;
        @(negedge clk); check("t5b_adr", wb_adr_o, 32'h700);
        check("t5b_data", cpu_data_o, 32'h0BADC0DE);
        step(); wb_ack_i = 0; cpu_ce_i = 0;

        // 6: reset in the middle of BUSY
        step(); req(1, 4'b0011, 32'h800, 32'h00000F0F);
        step();
        step(); rst = 1;
        @(negedge clk); check("t6_busy_before", {31'd0, wb_stb_o}, 32'd1);
        step(); rst = 0; cpu_ce_i = 0; wb_ack_i = 1;
        @(negedge clk); check("t6_cyc", {31'd0, wb_cyc_o}, 32'd0);
        check("t6_adr", wb_adr_o, 32'd0);
        check("t6_we", {31'd0, wb_we_o}, 32'd0);
        check("t6_sel", {28'd0, wb_sel_o}, 32'd0);
        step(); wb_ack_i = 0; req(0, 4'hF, 32'h900, 32'h0);
        @(negedge clk); check("t6_new_req", {31'd0, stallreq_o}, 32'd1);
        step(); wb_ack_i = 1; wb_dat_i = 32'h13572468;
        @(negedge clk); check("t6_new_adr", wb_adr_o, 32'h900);
        check("t6_new_data", cpu_data_o, 32'h13572468);
        step(); wb_ack_i = 0; cpu_ce_i = 0;
        step(); step();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
